i2c_reg_xfer_ctrl: RTL and testbench
====================================

// Module: i2c_reg_xfer_ctrl
// PURPOSE
//  Register-access sequencer directly upstream of i2c_master_byte_ctrl. Turns one host request
//  into a complete I2C register write (S,DEV+W,REG,DATA,P) or read (S,DEV+W,REG,Sr,DEV+R,DATA+NACK,P)
//  by issuing byte commands and consuming cmd_ack/ack_out/dout/i2c_al. Used to configure mic/codec devices.
// PARAMETERS
//  REG_AW   8   register address width; 8 or 16 (16 -> MSB byte sent first)
// PORTS
//  clk        in   1       clock
//  nReset     in   1       asynchronous active-low reset
//  rst        in   1       synchronous active-high reset (same effect as nReset)
//  req        in   1       start transaction (sampled only in IDLE)
//  rnw        in   1       1=read, 0=write
//  dev_addr   in   7       7-bit device address
//  reg_addr   in   REG_AW  register address
//  wdata      in   8       write data
//  busy       out  1       high from cycle after accepted req until done pulse
//  done       out  1       one-cycle pulse: transaction finished (ok or error)
//  rdata      out  8       read data; valid at done of successful read, held until next read
//  nack_err   out  1       with done: slave NACKed a written byte
//  al_err     out  1       with done: arbitration lost
//  bc_start, bc_stop, bc_read, bc_write  out 1  byte-ctrl command bits
//  bc_ack_in  out  1       ack bit to send after a read byte (always 1 = NACK)
//  bc_din     out  8       byte to write
//  bc_cmd_ack in   1       byte-ctrl command complete
//  bc_ack_out in   1       received ack bit (1 = NACK)
//  bc_dout    in   8       received byte
//  bc_al      in   1       arbitration lost
// BEHAVIOUR
//  - Reset: all outputs 0 (busy, done, errs, rdata=8'h00, all bc_* 0), state IDLE.
//  - IDLE + req: latch rnw/dev_addr/reg_addr/wdata; next cycle busy=1 and first command driven.
//  - Command handshake: all bc_* are registers, held stable until bc_cmd_ack=1; on that edge next
//    command (or all-zero) is loaded. Never drive read|write|stop while no command is pending.
//  - States/commands (each advances on bc_cmd_ack):
//    DEV_W: start+write, din={dev,0} -> REG_HI (REG_AW=16) else REG_LO
//    REG_HI: write, din=reg[15:8] -> REG_LO
//    REG_LO: write, din=reg[7:0]  -> WR_DATA (write) / DEV_R (read)
//    WR_DATA: write+stop, din=wdata -> FINISH
//    DEV_R: start+write, din={dev,1} -> RD_DATA
//    RD_DATA: read+stop, ack_in=1; rdata<=bc_dout on its cmd_ack -> FINISH
//    ERR_STOP: stop only -> FINISH (nack_err set)
//    FINISH: done=1 for one cycle, busy=0 same cycle, commands 0 -> IDLE
//  - NACK: at cmd_ack of DEV_W/REG_HI/REG_LO/DEV_R with bc_ack_out=1 -> ERR_STOP.
//    NACK on WR_DATA (stop already issued) -> FINISH with nack_err=1. Read-data ack ignored.
//  - bc_al=1 in any non-IDLE state: clear all bc_* next edge, go FINISH with al_err=1; no stop issued.
//    bc_al has priority over simultaneous bc_cmd_ack.
//  - nack_err/al_err valid only with done; cleared on next accepted req.
//  - req while busy ignored; req in FINISH cycle ignored. rst mid-transaction: immediate IDLE,
//    bc_* to 0, no done pulse.
//  - Latency: req to first command 1 cycle; final cmd_ack to done 1 cycle.
// TESTING
//  1 write dev=0x1A reg=0x10 data=0x5C, all ACK -> bc_din 0x34,0x10,0x5C; start on 1st, stop on 3rd; done, no err
//  2 read dev=0x1A reg=0x22, model returns 0xA7 -> bytes 0x34,0x22, Sr 0x35, read+stop ack_in=1; rdata=0xA7 at done
//  3 NACK on device byte (ack_out=1) -> stop-only command issued, done with nack_err=1, no reg byte
//  4 bc_al pulse during REG_LO -> bc_* cleared next cycle, done with al_err=1, busy=0
//  5 REG_AW=16 write reg=0x1234 -> bytes {dev,0},0x12,0x34,data; req during busy ignored
//  6 rst asserted mid RD_DATA -> all outputs 0 next cycle, no done; new req afterwards completes normally

Source files
------------

// File: rtl/i2c_reg_xfer_ctrl.sv
// Register-access sequencer: turns one host request into a full I2C register write or read
// by issuing byte commands to i2c_master_byte_ctrl and consuming its ack/data/arbitration status.
module i2c_reg_xfer_ctrl #(
    parameter int REG_AW = 8
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              rst,
    input  logic              req,
    input  logic              rnw,
    input  logic [6:0]        dev_addr,
    input  logic [REG_AW-1:0] reg_addr,
    input  logic [7:0]        wdata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rdata,
    output logic              nack_err,
    output logic              al_err,
    output logic              bc_start,
    output logic              bc_stop,
    output logic              bc_read,
    output logic              bc_write,
    output logic              bc_ack_in,
    output logic [7:0]        bc_din,
    input  logic              bc_cmd_ack,
    input  logic              bc_ack_out,
    input  logic [7:0]        bc_dout,
    input  logic              bc_al
);

    typedef enum logic [3:0] {
        IDLE, DEV_W, REG_HI, REG_LO, WR_DATA, DEV_R, RD_DATA, ERR_STOP, FINISH
    } state_t;

    state_t      state;
    state_t      ack_next;
    logic        rnw_q;
    logic [6:0]  dev_q;
    logic [15:0] reg_q;
    logic [7:0]  wdata_q;
    logic [15:0] reg_ext;
    logic        addr_byte;
    // {start, stop, read, write, ack_in, din}
    logic [12:0] cmd;

    assign {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din} = cmd;
    assign reg_ext   = 16'(reg_addr);
    assign addr_byte = (state == DEV_W) || (state == REG_HI) ||
                       (state == REG_LO) || (state == DEV_R);
    assign ack_next  = after_ack(state, rnw_q);

    function automatic logic [12:0] cmd_for(state_t s, logic [6:0] dev, logic [15:0] ra,
                                            logic [7:0] wd);
        case (s)
            DEV_W:    return {5'b10010, dev, 1'b0};
            REG_HI:   return {5'b00010, ra[15:8]};
            REG_LO:   return {5'b00010, ra[7:0]};
            WR_DATA:  return {5'b01010, wd};
            DEV_R:    return {5'b10010, dev, 1'b1};
            RD_DATA:  return {5'b01101, 8'h00};
            ERR_STOP: return {5'b01000, 8'h00};
            default:  return 13'h0000;
        endcase
    endfunction

    // Successor of a command state when its byte completes without NACK or arbitration loss.
    function automatic state_t after_ack(state_t s, logic r);
        case (s)
            DEV_W:   return (REG_AW == 16) ? REG_HI : REG_LO;
            REG_HI:  return REG_LO;
            REG_LO:  return r ? DEV_R : WR_DATA;
            DEV_R:   return RD_DATA;
            default: return FINISH;
        endcase
    endfunction

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= 8'h00;
            nack_err <= 1'b0;
            al_err   <= 1'b0;
            cmd      <= 13'h0000;
            rnw_q    <= 1'b0;
            dev_q    <= 7'h00;
            reg_q    <= 16'h0000;
            wdata_q  <= 8'h00;
        end else if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= 8'h00;
            nack_err <= 1'b0;
            al_err   <= 1'b0;
            cmd      <= 13'h0000;
            rnw_q    <= 1'b0;
            dev_q    <= 7'h00;
            reg_q    <= 16'h0000;
            wdata_q  <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        rnw_q    <= rnw;
                        dev_q    <= dev_addr;
                        reg_q    <= reg_ext;
                        wdata_q  <= wdata;
                        nack_err <= 1'b0;
                        al_err   <= 1'b0;
                        busy     <= 1'b1;
                        state    <= DEV_W;
                        cmd      <= cmd_for(DEV_W, dev_addr, reg_ext, wdata);
                    end
                end
                FINISH: state <= IDLE;
                default: begin
                    // Arbitration loss abandons the bus immediately; no stop can be issued.
                    if (bc_al) begin
                        cmd    <= 13'h0000;
                        al_err <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= FINISH;
                    end else if (bc_cmd_ack) begin
                        if (addr_byte && bc_ack_out) begin
                            nack_err <= 1'b1;
                            state    <= ERR_STOP;
                            cmd      <= cmd_for(ERR_STOP, dev_q, reg_q, wdata_q);
                        end else begin
                            if (state == WR_DATA && bc_ack_out)
                                nack_err <= 1'b1;
                            if (state == RD_DATA)
                                rdata <= bc_dout;
                            state <= ack_next;
                            cmd   <= cmd_for(ack_next, dev_q, reg_q, wdata_q);
                            if (ack_next == FINISH) begin
                                busy <= 1'b0;
                                done <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_xfer_ctrl.sv
// Bench for i2c_reg_xfer_ctrl: 8-bit and 16-bit register-address instances, a command-list
// model checked every cycle, and a byte-ctrl responder driving directed transactions.
`timescale 1ns/1ps
module tb_i2c_reg_xfer_ctrl;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        rnw = 1'b0;
    logic [6:0]  dev_addr = 7'h00;
    logic [15:0] reg_addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        bc_cmd_ack = 1'b0;
    logic        bc_ack_out = 1'b0;
    logic        bc_al = 1'b0;
    logic [7:0]  bc_dout = 8'h00;
    logic        sel16 = 1'b0;
    logic        chk_en = 1'b0;

    always #5 clk = ~clk;

    logic busy8, done8, nack8, al8, s8, p8, r8, w8, a8;
    logic busy16, done16, nack16, al16, s16, p16, r16, w16, a16;
    logic [7:0] rd8, din8, rd16, din16;

    i2c_reg_xfer_ctrl #(.REG_AW(8)) u_dut8 (
        .clk(clk), .nReset(nReset), .rst(rst), .req(req & ~sel16), .rnw(rnw),
        .dev_addr(dev_addr), .reg_addr(reg_addr[7:0]), .wdata(wdata),
        .busy(busy8), .done(done8), .rdata(rd8), .nack_err(nack8), .al_err(al8),
        .bc_start(s8), .bc_stop(p8), .bc_read(r8), .bc_write(w8), .bc_ack_in(a8),
        .bc_din(din8), .bc_cmd_ack(bc_cmd_ack), .bc_ack_out(bc_ack_out),
        .bc_dout(bc_dout), .bc_al(bc_al)
    );

    i2c_reg_xfer_ctrl #(.REG_AW(16)) u_dut16 (
        .clk(clk), .nReset(nReset), .rst(rst), .req(req & sel16), .rnw(rnw),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
        .busy(busy16), .done(done16), .rdata(rd16), .nack_err(nack16), .al_err(al16),
        .bc_start(s16), .bc_stop(p16), .bc_read(r16), .bc_write(w16), .bc_ack_in(a16),
        .bc_din(din16), .bc_cmd_ack(bc_cmd_ack), .bc_ack_out(bc_ack_out),
        .bc_dout(bc_dout), .bc_al(bc_al)
    );

    logic        o_busy, o_done, o_nack, o_al;
    logic [7:0]  o_rdata;
    logic [12:0] o_cmd;
    assign o_busy  = sel16 ? busy16 : busy8;
    assign o_done  = sel16 ? done16 : done8;
    assign o_nack  = sel16 ? nack16 : nack8;
    assign o_al    = sel16 ? al16 : al8;
    assign o_rdata = sel16 ? rd16 : rd8;
    assign o_cmd   = sel16 ? {s16, p16, r16, w16, a16, din16} : {s8, p8, r8, w8, a8, din8};

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is the list of byte commands it must issue; each ack pops one.
    // Command word is {start, stop, read, write, ack_in, din}.
    logic [12:0] cmd_list[$];
    logic        m_busy = 1'b0, m_done = 1'b0, m_nack = 1'b0, m_al = 1'b0;
    logic [12:0] m_cmd = 13'h0000;
    logic [7:0]  m_rdata[2] = '{8'h00, 8'h00};

    initial forever begin
        @(posedge clk or negedge nReset);
        if (!nReset || rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_al = 1'b0; m_cmd = 13'h0000;
            m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
            cmd_list.delete();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_busy) begin
            if (req) begin
                cmd_list.delete();
                cmd_list.push_back({5'b10010, dev_addr, 1'b0});
                if (sel16) cmd_list.push_back({5'b00010, reg_addr[15:8]});
                cmd_list.push_back({5'b00010, reg_addr[7:0]});
                if (!rnw) begin
                    cmd_list.push_back({5'b01010, wdata});
                end else begin
                    cmd_list.push_back({5'b10010, dev_addr, 1'b1});
                    cmd_list.push_back({5'b01101, 8'h00});
                end
                m_cmd = cmd_list.pop_front();
                m_busy = 1'b1; m_nack = 1'b0; m_al = 1'b0;
            end
        end else if (bc_al) begin
            m_cmd = 13'h0000; cmd_list.delete();
            m_busy = 1'b0; m_done = 1'b1; m_al = 1'b1;
        end else if (bc_cmd_ack) begin
            // An unacknowledged address byte replaces the rest of the list with a lone stop.
            if (m_cmd[9] && !m_cmd[11] && bc_ack_out) begin
                cmd_list.delete();
                cmd_list.push_back({5'b01000, 8'h00});
                m_nack = 1'b1;
            end else if (m_cmd[10]) begin
                m_rdata[sel16] = bc_dout;
            end else if (m_cmd[11] && m_cmd[9] && bc_ack_out) begin
                m_nack = 1'b1;
            end
            if (cmd_list.size() == 0) begin
                m_cmd = 13'h0000; m_busy = 1'b0; m_done = 1'b1;
            end else begin
                m_cmd = cmd_list.pop_front();
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("busy", o_busy, m_busy);
            check("done", o_done, m_done);
            check("cmd_bits", o_cmd[12:8], m_cmd[12:8]);
            if (m_cmd[9]) check("din", o_cmd[7:0], m_cmd[7:0]);
            check("rdata", o_rdata, m_rdata[sel16]);
            if (m_done) begin
                check("nack_err", o_nack, m_nack);
                check("al_err", o_al, m_al);
            end
        end
    end

    // Responder: records each acknowledged command (din masked unless a write).
    logic [12:0] obs_q[$];
    logic [12:0] exp_q[$];
    logic        res_done, res_nack, res_al;
    logic [7:0]  res_rdata;

    task automatic run_txn(input logic is16, input logic r, input logic [6:0] dev,
                           input logic [15:0] ra, input logic [7:0] wd, input int nack_idx,
                           input int al_idx, input int rst_idx, input logic [7:0] rd_byte,
                           input logic hold_req);
        int idx;
        int w;
        bit fin;
        obs_q.delete();
        res_done = 1'b0; res_nack = 1'b0; res_al = 1'b0; res_rdata = 8'h00;
        sel16 = is16; rnw = r; dev_addr = dev; reg_addr = ra; wdata = wd; bc_dout = rd_byte;
        req = 1'b1;
        @(posedge clk); #1;
        if (!hold_req) req = 1'b0;
        idx = 0;
        fin = 1'b0;
        while (!fin && idx < 8) begin
            w = 0;
            while (w < 30 && o_cmd[12:9] == 4'h0 && !o_done) begin
                @(posedge clk); #1;
                w++;
            end
            if (o_done) begin
                res_done = 1'b1; res_nack = o_nack; res_al = o_al; res_rdata = o_rdata;
                fin = 1'b1;
            end else if (w == 30) begin
                check("cmd_timeout", 32'd0, 32'd1);
                fin = 1'b1;
            end else begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                if (idx == rst_idx) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    fin = 1'b1;
                end else begin
                    if (idx == al_idx) begin
                        bc_al = 1'b1;
                    end else begin
                        bc_cmd_ack = 1'b1;
                        bc_ack_out = (idx == nack_idx);
                        obs_q.push_back(o_cmd[9] ? o_cmd : {o_cmd[12:8], 8'h00});
                    end
                    @(posedge clk); #1;
                    bc_al = 1'b0; bc_cmd_ack = 1'b0; bc_ack_out = 1'b0;
                end
                idx++;
            end
        end
        if (hold_req) begin @(posedge clk); #1; req = 1'b0; end
        check("done_seen", res_done, (rst_idx < 0) ? 32'd1 : 32'd0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic check_obs(input string name);
        check($sformatf("%s_len", name), obs_q.size(), exp_q.size());
        foreach (exp_q[i])
            check($sformatf("%s_cmd%0d", name, i), (i < obs_q.size()) ? obs_q[i] : 13'h1fff, exp_q[i]);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 nReset = 1'b1;
        check("rst_busy", o_busy, 32'd0);
        check("rst_done", o_done, 32'd0);
        check("rst_rdata", o_rdata, 32'h00);
        check("rst_cmd", o_cmd, 32'h0);
        check("rst_cmd16", {s16, p16, r16, w16, a16, din16}, 32'h0);
        chk_en = 1'b1;

        // Plain write
        run_txn(1'b0, 1'b0, 7'h1A, 16'h0010, 8'h5C, -1, -1, -1, 8'h00, 1'b0);
        exp_q = '{{5'b10010, 8'h34}, {5'b00010, 8'h10}, {5'b01010, 8'h5C}};
        check_obs("t1");
        check("t1_nack", res_nack, 32'd0);
        check("t1_al", res_al, 32'd0);

        // Read with repeated start
        run_txn(1'b0, 1'b1, 7'h1A, 16'h0022, 8'h00, -1, -1, -1, 8'hA7, 1'b0);
        exp_q = '{{5'b10010, 8'h34}, {5'b00010, 8'h22}, {5'b10010, 8'h35}, {5'b01101, 8'h00}};
        check_obs("t2");
        check("t2_rdata", res_rdata, 32'hA7);
        check("t2_nack", res_nack, 32'd0);

        // NACK on device address byte
        run_txn(1'b0, 1'b0, 7'h1A, 16'h0010, 8'h5C, 0, -1, -1, 8'h00, 1'b0);
        exp_q = '{{5'b10010, 8'h34}, {5'b01000, 8'h00}};
        check_obs("t3");
        check("t3_nack", res_nack, 32'd1);
        check("t3_rdata_held", res_rdata, 32'hA7);

        // Arbitration lost while the register byte is pending
        run_txn(1'b0, 1'b0, 7'h1A, 16'h0010, 8'h5C, -1, 1, -1, 8'h00, 1'b0);
        exp_q = '{{5'b10010, 8'h34}};
        check_obs("t4");
        check("t4_al", res_al, 32'd1);
        check("t4_nack", res_nack, 32'd0);

        // NACK on the write data byte: stop already issued, no extra command
        run_txn(1'b0, 1'b0, 7'h21, 16'h0003, 8'h99, 2, -1, -1, 8'h00, 1'b0);
        exp_q = '{{5'b10010, 8'h42}, {5'b00010, 8'h03}, {5'b01010, 8'h99}};
        check_obs("t4b");
        check("t4b_nack", res_nack, 32'd1);

        // NACK on the read-direction device byte
        run_txn(1'b0, 1'b1, 7'h1A, 16'h0022, 8'h00, 2, -1, -1, 8'h55, 1'b0);
        exp_q = '{{5'b10010, 8'h34}, {5'b00010, 8'h22}, {5'b10010, 8'h35}, {5'b01000, 8'h00}};
        check_obs("t4c");
        check("t4c_nack", res_nack, 32'd1);
        check("t4c_rdata_held", res_rdata, 32'hA7);

        // Synchronous reset while the read-data command is pending
        run_txn(1'b0, 1'b1, 7'h1A, 16'h0040, 8'h00, -1, -1, 3, 8'h66, 1'b0);
        check("t6_busy", o_busy, 32'd0);
        check("t6_cmd", o_cmd, 32'h0);
        check("t6_rdata", o_rdata, 32'h00);
        run_txn(1'b0, 1'b0, 7'h50, 16'h0007, 8'hC3, -1, -1, -1, 8'h00, 1'b0);
        exp_q = '{{5'b10010, 8'hA0}, {5'b00010, 8'h07}, {5'b01010, 8'hC3}};
        check_obs("t6b");
        check("t6b_nack", res_nack, 32'd0);

        // 16-bit register address, req held high through busy and the done cycle
        run_txn(1'b1, 1'b0, 7'h1A, 16'h1234, 8'h9E, -1, -1, -1, 8'h00, 1'b1);
        exp_q = '{{5'b10010, 8'h34}, {5'b00010, 8'h12}, {5'b00010, 8'h34}, {5'b01010, 8'h9E}};
        check_obs("t5");
        check("t5_idle_after", o_busy, 32'd0);

        // 16-bit register read
        run_txn(1'b1, 1'b1, 7'h3C, 16'hBEEF, 8'h00, -1, -1, -1, 8'h4D, 1'b0);
        exp_q = '{{5'b10010, 8'h78}, {5'b00010, 8'hBE}, {5'b00010, 8'hEF},
                  {5'b10010, 8'h79}, {5'b01101, 8'h00}};
        check_obs("t5b");
        check("t5b_rdata", res_rdata, 32'h4D);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
